seg7_scan_ctrl: RTL and testbench

Time-multiplexing scan controller that shares one BCD-to-7-segment decoder across `NUM_DIGITS` common-anode/cathode digit positions. It sits between the register/datapath that produces BCD values and the decoder plus digit drivers. Each digit gets a fixed time slot: a blanking interval followed by a display interval. New display values are double-buffered so a frame never shows mixed old and new digits.

---
 rtl/seg7_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed BCD digit scanner sharing one 7-segment decoder, with a
// double-buffered display image. Define SEG7_LZ_BLANK_EN to enable leading-zero suppression.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SHOW_CYCLES  = 240,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [3:0]              bcd_out,
    output logic                    dec_en,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);
    localparam int MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0]         SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL0       = NUM_DIGITS'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    wrap_q, wrap_d;
    logic [4*NUM_DIGITS-1:0] act_q, act_d, pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                    pend_full_q, pend_full_d;
    logic                    upd_ready_q, upd_ready_d;
    logic                    accept_s, swap_s, dark_s;
    logic [3:0]              nib_s;
    logic [3:0]              bcd_q, bcd_d;
    logic                    dec_en_q, dec_en_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    fd_q, fd_d;

`ifdef SEG7_LZ_BLANK_EN
    function automatic logic lz_dark(input logic [4*NUM_DIGITS-1:0] nib,
                                     input logic [NUM_DIGITS-1:0]   dp,
                                     input logic [IW-1:0]           idx);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((j >= int'(idx)) && (nib[j*4 +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
        return (idx != {IW{1'b0}}) && upper_zero && !dp[idx];
    endfunction

    assign dark_s = lz_dark(act_d, act_dp_d, idx_q);
`else
    assign dark_s = 1'b0;
`endif

    // Outputs lag the sequencer by one cycle, so they decode the image that is active next cycle.
    assign nib_s = act_d[{idx_q, 2'b00} +: 4];

    // Slot sequencer next-state: blank interval, then show interval, per digit.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            idx_d   = {IW{1'b0}};
            cnt_d   = {CW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    idx_d   = {IW{1'b0}};
                    cnt_d   = {CW{1'b0}};
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CW'(1'b1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = {CW{1'b0}};
                        if (idx_q == IDX_LAST) begin
                            idx_d  = {IW{1'b0}};
                            wrap_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1'b1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1'b1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = {IW{1'b0}};
                    cnt_d   = {CW{1'b0}};
                end
            endcase
        end
    end

    // Double buffer: pending image moves to active at a frame boundary or whenever idle.
    always_comb begin
        accept_s    = upd_valid && upd_ready_q;
        swap_s      = pend_full_q && (wrap_q || (state_q == ST_IDLE));
        act_d       = act_q;
        act_dp_d    = act_dp_q;
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        if (swap_s) begin
            act_d    = pend_q;
            act_dp_d = pend_dp_q;
        end else begin
            act_d    = act_q;
            act_dp_d = act_dp_q;
        end
        if (accept_s) begin
            pend_d      = digits_in;
            pend_dp_d   = dp_in;
            pend_full_d = 1'b1;
        end else if (swap_s) begin
            pend_full_d = 1'b0;
        end else begin
            pend_full_d = pend_full_q;
        end
        // Ready reopens only the cycle after the swap completes.
        upd_ready_d = !pend_full_d && !swap_s;
    end

    // Output decode from the current slot; a low enable darkens everything on the next edge.
    always_comb begin
        bcd_d    = 4'd0;
        dec_en_d = 1'b0;
        dp_d     = 1'b0;
        sel_d    = {NUM_DIGITS{1'b0}};
        fd_d     = 1'b0;
        if (en) begin
            case (state_q)
                ST_BLANK: begin
                    bcd_d = nib_s;
                    fd_d  = wrap_q;
                end
                ST_SHOW: begin
                    bcd_d = nib_s;
                    if (!dark_s) begin
                        dec_en_d = 1'b1;
                        dp_d     = act_dp_d[idx_q];
                        sel_d    = SEL0 << idx_q;
                    end else begin
                        dec_en_d = 1'b0;
                        sel_d    = {NUM_DIGITS{1'b0}};
                    end
                end
                default: begin
                    bcd_d = 4'd0;
                end
            endcase
        end else begin
            bcd_d = 4'd0;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= {IW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    // Display image buffers and handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q       <= {(4*NUM_DIGITS){1'b0}};
            act_dp_q    <= {NUM_DIGITS{1'b0}};
            pend_q      <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_q   <= {NUM_DIGITS{1'b0}};
            pend_full_q <= 1'b0;
            upd_ready_q <= 1'b1;
        end else begin
            act_q       <= act_d;
            act_dp_q    <= act_dp_d;
            pend_q      <= pend_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
            upd_ready_q <= upd_ready_d;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q    <= 4'd0;
            dec_en_q <= 1'b0;
            dp_q     <= 1'b0;
            sel_q    <= {NUM_DIGITS{1'b0}};
            fd_q     <= 1'b0;
        end else begin
            bcd_q    <= bcd_d;
            dec_en_q <= dec_en_d;
            dp_q     <= dp_d;
            sel_q    <= sel_d;
            fd_q     <= fd_d;
        end
    end

    assign upd_ready  = upd_ready_q;
    assign bcd_out    = bcd_q;
    assign dec_en     = dec_en_q;
    assign dp_out     = dp_q;
    assign digit_sel  = sel_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NUM_DIGITS=4, SHOW_CYCLES=8, BLANK_CYCLES=2.
module tb_seg7_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  bcd_out;
    logic        dec_en;
    logic        dp_out;
    logic [3:0]  digit_sel;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    // Observed vector: {bcd_out, dec_en, dp_out, digit_sel, frame_done, upd_ready}
    logic [11:0] obs_s;
    localparam logic [11:0] DARK_RDY  = 12'h001;
    localparam logic [11:0] DARK_BUSY = 12'h000;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (4),
        .SHOW_CYCLES (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .bcd_out   (bcd_out),
        .dec_en    (dec_en),
        .dp_out    (dp_out),
        .digit_sel (digit_sel),
        .frame_done(frame_done)
    );

    assign obs_s = {bcd_out, dec_en, dp_out, digit_sel, frame_done, upd_ready};

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%03h expected=%03h", tag, obs, exp);
        end
    endtask

    // Expected outputs k cycles after the enable edge: 10-cycle slots (2 dark, 8 shown), 40-cycle frames.
    function automatic logic [11:0] exp_vec(input int k, input logic [15:0] d,
                                            input logic [3:0] dp, input logic rdy);
        int         p, dig, s;
        logic [3:0] nib, sel;
        logic       dec, dpo, fd, dark;
        p    = (k - 1) % 40;
        dig  = p / 10;
        s    = p % 10;
        nib  = d[dig*4 +: 4];
        sel  = 4'b0000;
        dec  = 1'b0;
        dpo  = 1'b0;
        fd   = (k > 1) && (p == 0);
        dark = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
        dark = (dig > 0) && !dp[dig] && ((d >> (dig*4)) == 16'h0000);
`endif
        if ((s >= 2) && !dark) begin
            sel = 4'b0001 << dig;
            dec = 1'b1;
            dpo = dp[dig];
        end
        return {nib, dec, dpo, sel, fd, rdy};
    endfunction

    task automatic scan_chk(input string tag, input int k0, input int k1,
                            input logic [15:0] d, input logic [3:0] dp);
        for (int k = k0; k <= k1; k++) begin
            @(negedge clk);
            chk($sformatf("%s k=%0d", tag, k), obs_s, exp_vec(k, d, dp, 1'b1));
        end
    endtask

    task automatic load_idle(input logic [15:0] d, input logic [3:0] dp);
        upd_valid = 1'b1;
        digits_in = d;
        dp_in     = dp;
        @(negedge clk);
        upd_valid = 1'b0;
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        chk("load_accept", obs_s, DARK_BUSY);
        @(negedge clk);
        chk("load_swap", obs_s, DARK_BUSY);
        @(negedge clk);
        chk("load_ready", obs_s, DARK_RDY);
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        upd_valid = 1'b0;
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("reset", obs_s, DARK_RDY);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_en0", obs_s, DARK_RDY);
        end

        load_idle(16'h1234, 4'b0000);
        en = 1'b1;
        @(negedge clk);
        chk("start_k0", obs_s, DARK_RDY);
        // Three frames and a bit; 5678 offered mid-frame, a 9999 re-offer while busy must be ignored.
        for (int k = 1; k <= 145; k++) begin
            @(negedge clk);
            chk($sformatf("scan k=%0d", k), obs_s,
                exp_vec(k, (k <= 40) ? 16'h1234 : 16'h5678, 4'b0000, !((k >= 15) && (k <= 41))));
            if (k == 14) begin
                upd_valid = 1'b1;
                digits_in = 16'h5678;
            end
            if (k == 15) digits_in = 16'h9999;
            if (k == 30) begin
                upd_valid = 1'b0;
                digits_in = 16'h0000;
            end
            if (k == 145) en = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("en_low_dark", obs_s, DARK_RDY);
        end

        en = 1'b1;
        @(negedge clk);
        chk("restart_k0", obs_s, DARK_RDY);
        scan_chk("restart", 1, 12, 16'h5678, 4'b0000);
        upd_valid = 1'b1;
        digits_in = 16'h4321;
        @(negedge clk);
        upd_valid = 1'b0;
        digits_in = 16'h0000;
        chk("pend_k13", obs_s, exp_vec(13, 16'h5678, 4'b0000, 1'b0));
        @(negedge clk);
        chk("pend_k14", obs_s, exp_vec(14, 16'h5678, 4'b0000, 1'b0));
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("async_reset", obs_s, DARK_RDY);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_idle", obs_s, DARK_RDY);
        end
        en = 1'b1;
        @(negedge clk);
        chk("post_reset_k0", obs_s, DARK_RDY);
        scan_chk("post_reset", 1, 13, 16'h0000, 4'b0000);

        en = 1'b0;
        @(negedge clk);
        chk("lz_idle", obs_s, DARK_RDY);
        load_idle(16'h0070, 4'b0000);
        en = 1'b1;
        @(negedge clk);
        chk("lz_k0", obs_s, DARK_RDY);
        scan_chk("lz_nodp", 1, 40, 16'h0070, 4'b0000);

        en = 1'b0;
        @(negedge clk);
        chk("lzdp_idle", obs_s, DARK_RDY);
        load_idle(16'h0070, 4'b1000);
        en = 1'b1;
        @(negedge clk);
        chk("lzdp_k0", obs_s, DARK_RDY);
        scan_chk("lz_dp3", 1, 40, 16'h0070, 4'b1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
